sonar_varredura_uc: RTL

//  Parametrised sequencing unit for the next-gen sonar: sweeps N_POSICOES servo positions, triggers N_CANAIS

---
 rtl/sonar_varredura_uc_pkg.sv | 27 ++
 rtl/sonar_varredura_uc_if.sv | 40 ++++
 rtl/sonar_varredura_uc_contador.sv | 33 +++
 rtl/sonar_varredura_uc.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sonar_varredura_uc_pkg.sv
// rtl/sonar_varredura_uc_pkg.sv - shared state encoding, mode constants and width helper
package sonar_varredura_uc_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    POSICIONA      = 4'd1,
    MEDE           = 4'd2,
    AGUARDA_SENSOR = 4'd3,
    TRANSMITE      = 4'd4,
    AGUARDA_SERIAL = 4'd5,
    PROX_CARACTERE = 4'd6,
    PROX_CANAL     = 4'd7,
    PROX_POSICAO   = 4'd8,
    FIM            = 4'd9
  } estado_t;

  localparam logic [1:0] MODO_PINGPONG = 2'b00;
  localparam logic [1:0] MODO_WRAP     = 2'b01;
  localparam logic [1:0] MODO_UNICA    = 2'b10;
  localparam logic [1:0] MODO_FIXA     = 2'b11;

  // Index width for n items, never narrower than one bit.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sonar_varredura_uc_if.sv
// rtl/sonar_varredura_uc_if.sv - control/status bundle between sequencer and sonar datapath
interface sonar_varredura_uc_if
  import sonar_varredura_uc_pkg::*;
#(
  parameter int N_CANAIS     = 2,
  parameter int N_POSICOES   = 8,
  parameter int N_CARACTERES = 8
);
  localparam int W_CAN = largura(N_CANAIS);
  localparam int W_POS = largura(N_POSICOES);
  localparam int W_CAR = largura(N_CARACTERES);

  logic                ligar;
  logic [1:0]          modo;
  logic [W_POS-1:0]    posicao_fixa;
  logic [N_CANAIS-1:0] sensor_pronto;
  logic                serial_pronto;
  logic [N_CANAIS-1:0] medir;
  logic                transmissao;
  logic [W_CAN-1:0]    sel_canal;
  logic [W_POS-1:0]    sel_posicao;
  logic [W_CAR-1:0]    sel_caractere;
  logic                fim_posicao;
  logic [N_CANAIS-1:0] erro_timeout;
  logic                ocupado;
  logic [3:0]          db_estado;

  modport master (
    input  ligar, modo, posicao_fixa, sensor_pronto, serial_pronto,
    output medir, transmissao, sel_canal, sel_posicao, sel_caractere,
           fim_posicao, erro_timeout, ocupado, db_estado
  );

  modport slave (
    output ligar, modo, posicao_fixa, sensor_pronto, serial_pronto,
    input  medir, transmissao, sel_canal, sel_posicao, sel_caractere,
           fim_posicao, erro_timeout, ocupado, db_estado
  );

endinterface

// File: rtl/sonar_varredura_uc_contador.sv
// rtl/sonar_varredura_uc_contador.sv - modulo-MODULO cycle counter, fim flags the last count
module contador_m
  import sonar_varredura_uc_pkg::*;
#(
  parameter int MODULO = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);
  localparam int            W      = largura(MODULO);
  localparam logic [W-1:0]  ULTIMO = W'(MODULO - 1);

  logic [W-1:0] cont_q, cont_d;

  always_comb begin
    cont_d = cont_q;
    if (zera)
      cont_d = '0;
    else if (conta)
      cont_d = (cont_q == ULTIMO) ? '0 : cont_q + W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cont_q <= '0;
    else        cont_q <= cont_d;
  end

  assign fim = (cont_q == ULTIMO);

endmodule

// File: rtl/sonar_varredura_uc.sv
// rtl/sonar_varredura_uc.sv - sonar sweep sequencer: position, per-channel measure, per-char serial send
module sonar_varredura_uc
  import sonar_varredura_uc_pkg::*;
#(
  parameter int N_CANAIS     = 2,
  parameter int N_POSICOES   = 8,
  parameter int N_CARACTERES = 8,
  parameter int T_ESPERA     = 50000000,
  parameter int T_TIMEOUT    = 2500000
) (
  input  logic                   clock,
  input  logic                   reset,
  sonar_varredura_uc_if.master   bus
);
  localparam int W_CAN = largura(N_CANAIS);
  localparam int W_POS = largura(N_POSICOES);
  localparam int W_CAR = largura(N_CARACTERES);

  localparam logic [W_CAN-1:0] ULT_CANAL = W_CAN'(N_CANAIS - 1);
  localparam logic [W_POS-1:0] ULT_POS   = W_POS'(N_POSICOES - 1);
  localparam logic [W_CAR-1:0] ULT_CAR   = W_CAR'(N_CARACTERES - 1);

  estado_t             estado_q, estado_d;
  logic [1:0]          modo_q, modo_d;
  logic                desce_q, desce_d;
  logic [W_CAN-1:0]    canal_q, canal_d;
  logic [W_POS-1:0]    pos_q, pos_d;
  logic [W_CAR-1:0]    car_q, car_d;
  logic [N_CANAIS-1:0] erro_q, erro_d;
  logic [N_CANAIS-1:0] medir_q, medir_d;
  logic                transm_q, transm_d;
  logic                fim_pos_q, fim_pos_d;
  logic                ocupado_q, ocupado_d;

  logic             espera_zera, espera_conta, espera_fim;
  logic             timeout_zera, timeout_conta, timeout_fim;
  logic [W_POS-1:0] fixa_lim;

  assign espera_conta  = (estado_q == POSICIONA);
  assign espera_zera   = !espera_conta;
  assign timeout_conta = (estado_q == AGUARDA_SENSOR);
  assign timeout_zera  = !timeout_conta;

  contador_m #(.MODULO(T_ESPERA)) u_espera (
    .clock (clock),
    .reset (reset),
    .zera  (espera_zera),
    .conta (espera_conta),
    .fim   (espera_fim)
  );

  contador_m #(.MODULO(T_TIMEOUT)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (timeout_zera),
    .conta (timeout_conta),
    .fim   (timeout_fim)
  );

  // Out-of-range fixed positions are clamped so the servo index stays valid.
  assign fixa_lim = (int'(bus.posicao_fixa) >= N_POSICOES) ? ULT_POS : bus.posicao_fixa;

  always_comb begin
    estado_d = estado_q;
    modo_d   = modo_q;
    desce_d  = desce_q;
    canal_d  = canal_q;
    pos_d    = pos_q;
    car_d    = car_q;
    erro_d   = erro_q;
    case (estado_q)
      INICIAL: begin
        if (bus.ligar) begin
          modo_d   = bus.modo;
          erro_d   = '0;
          canal_d  = '0;
          car_d    = '0;
          desce_d  = 1'b0;
          pos_d    = (bus.modo == MODO_FIXA) ? fixa_lim : '0;
          estado_d = POSICIONA;
        end
      end
      POSICIONA: if (espera_fim) estado_d = MEDE;
      MEDE:      estado_d = AGUARDA_SENSOR;
      AGUARDA_SENSOR: begin
        if (bus.sensor_pronto[canal_q]) begin
          estado_d = TRANSMITE;
        end else if (timeout_fim) begin
          erro_d[canal_q] = 1'b1;
          estado_d        = TRANSMITE;
        end
      end
      TRANSMITE:      estado_d = AGUARDA_SERIAL;
      AGUARDA_SERIAL: if (bus.serial_pronto) estado_d = PROX_CARACTERE;
      PROX_CARACTERE: begin
        if (car_q != ULT_CAR) begin
          car_d    = car_q + W_CAR'(1);
          estado_d = TRANSMITE;
        end else begin
          car_d    = '0;
          estado_d = PROX_CANAL;
        end
      end
      PROX_CANAL: begin
        if (canal_q != ULT_CANAL) begin
          canal_d  = canal_q + W_CAN'(1);
          estado_d = MEDE;
        end else begin
          canal_d  = '0;
          estado_d = PROX_POSICAO;
        end
      end
      PROX_POSICAO: begin
        if (!bus.ligar) begin
          estado_d = INICIAL;
        end else begin
          estado_d = POSICIONA;
          case (modo_q)
            MODO_PINGPONG: begin
              if (!desce_q) begin
                if (pos_q == ULT_POS) begin
                  desce_d = 1'b1;
                  pos_d   = pos_q - W_POS'(1);
                end else begin
                  pos_d   = pos_q + W_POS'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  desce_d = 1'b0;
                  pos_d   = pos_q + W_POS'(1);
                end else begin
                  pos_d   = pos_q - W_POS'(1);
                end
              end
            end
            MODO_WRAP:  pos_d = (pos_q == ULT_POS) ? '0 : pos_q + W_POS'(1);
            MODO_UNICA: begin
              if (pos_q == ULT_POS) estado_d = FIM;
              else                  pos_d    = pos_q + W_POS'(1);
            end
            default:    pos_d = fixa_lim;
          endcase
        end
      end
      FIM:     if (!bus.ligar) estado_d = INICIAL;
      default: estado_d = INICIAL;
    endcase
  end

  // Pulse outputs are derived from the next state so they line up with the state they belong to.
  always_comb begin
    medir_d   = (estado_d == MEDE) ? (N_CANAIS'(1) << canal_d) : '0;
    transm_d  = (estado_d == TRANSMITE);
    fim_pos_d = (estado_d == PROX_POSICAO);
    ocupado_d = (estado_d != INICIAL) && (estado_d != FIM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      modo_q    <= MODO_PINGPONG;
      desce_q   <= 1'b0;
      canal_q   <= '0;
      pos_q     <= '0;
      car_q     <= '0;
      erro_q    <= '0;
      medir_q   <= '0;
      transm_q  <= 1'b0;
      fim_pos_q <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      modo_q    <= modo_d;
      desce_q   <= desce_d;
      canal_q   <= canal_d;
      pos_q     <= pos_d;
      car_q     <= car_d;
      erro_q    <= erro_d;
      medir_q   <= medir_d;
      transm_q  <= transm_d;
      fim_pos_q <= fim_pos_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign bus.medir         = medir_q;
  assign bus.transmissao   = transm_q;
  assign bus.sel_canal     = canal_q;
  assign bus.sel_posicao   = pos_q;
  assign bus.sel_caractere = car_q;
  assign bus.fim_posicao   = fim_pos_q;
  assign bus.erro_timeout  = erro_q;
  assign bus.ocupado       = ocupado_q;
  assign bus.db_estado     = estado_q;

endmodule
